// File: rtl/btn_debounce.sv
// Button/switch conditioner: two-flop synchroniser, stable-count debounce,
// and registered rise/fall pulses plus a press-toggled latch per channel.
module btn_debounce #(
    parameter int N            = 2,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_level,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall,
    output logic [N-1:0] o_toggle
);

    localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [CW-1:0] cnt [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            o_level  <= '0;
            o_rise   <= '0;
            o_fall   <= '0;
            o_toggle <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= i_btn;
            s2     <= s1;
            o_rise <= '0;
            o_fall <= '0;
            for (int i = 0; i < N; i++) begin
                // Any sample matching the accepted level restarts the count.
                if (s2[i] == o_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]     <= '0;
                    o_level[i] <= s2[i];
                    o_rise[i]  <= s2[i];
                    o_fall[i]  <= ~s2[i];
                    if (s2[i]) begin
                        o_toggle[i] <= ~o_toggle[i];
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CNT=4: a vector table for
// reset/press/bounce plus hand-written glitch, toggle and reset-mid-count sequences.
module tb_btn_debounce;

    localparam int N  = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] i_btn = '0;
    logic [N-1:0] o_level;
    logic [N-1:0] o_rise;
    logic [N-1:0] o_fall;
    logic [N-1:0] o_toggle;

    int checks = 0;
    int errors = 0;

    btn_debounce #(.N(N), .DEBOUNCE_CNT(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_toggle (o_toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] btn;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] tog;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] b, input logic [1:0] lvl,
                       input logic [1:0] rise, input logic [1:0] fall,
                       input logic [1:0] tog, input string name, input int n);
        vec_t v;
        v.rst = r; v.btn = b; v.lvl = lvl; v.rise = rise;
        v.fall = fall; v.tog = tog; v.name = name;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the following rising edge.
    task automatic step(input logic r, input logic [1:0] b, input logic [1:0] lvl,
                        input logic [1:0] rise, input logic [1:0] fall,
                        input logic [1:0] tog, input string name);
        @(negedge clk);
        reset = r;
        i_btn = b;
        @(posedge clk);
        #1;
        checks++;
        if ({o_level, o_rise, o_fall, o_toggle} !== {lvl, rise, fall, tog}) begin
            errors++;
            $display("FAIL %s @%0t: level/rise/fall/toggle got %b/%b/%b/%b expected %b/%b/%b/%b",
                     name, $time, o_level, o_rise, o_fall, o_toggle, lvl, rise, fall, tog);
        end
    endtask

    logic [1:0] prev_t;
    logic [1:0] new_t;

    initial begin
        // Test 1: reset with both buttons held, then rise on 6th edge after release
        add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "t1_in_reset", 3);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "t1_wait", 5);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, "t1_rise", 1);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, "t1_hold", 1);
        // Test 2: clean press and release on ch0
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t2_reset", 2);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "t2_press_wait", 5);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, "t2_rise", 1);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, "t2_hold", 1);
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, "t2_release_wait", 5);
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, "t2_fall", 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "t2_idle", 2);
        // Test 3: bounce on ch1 with 2-cycle dwell, then stable 1
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t3_reset", 2);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t3_bounce", 2);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t3_bounce", 2);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t3_bounce", 2);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t3_bounce", 2);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t3_stable_wait", 5);
        add(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, "t3_rise", 1);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, "t3_hold", 3);

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].btn, vecs[i].lvl, vecs[i].rise,
                 vecs[i].fall, vecs[i].tog, vecs[i].name);

        // Test 4: ch0 high for DC-1 cycles must never be accepted
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t4_reset");
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t4_reset");
        for (int k = 0; k < 3; k++)
            step(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "t4_glitch");
        for (int k = 0; k < 8; k++)
            step(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t4_after");

        // Test 5: three presses on ch0, ch1 held low
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t5_reset");
        for (int p = 0; p < 3; p++) begin
            prev_t = (p == 1) ? 2'b01 : 2'b00;
            new_t  = (p == 1) ? 2'b00 : 2'b01;
            for (int k = 0; k < 5; k++)
                step(0, 2'b01, 2'b00, 2'b00, 2'b00, prev_t, "t5_press_wait");
            step(0, 2'b01, 2'b01, 2'b01, 2'b00, new_t, "t5_rise");
            step(0, 2'b01, 2'b01, 2'b00, 2'b00, new_t, "t5_hold");
            for (int k = 0; k < 5; k++)
                step(0, 2'b00, 2'b01, 2'b00, 2'b00, new_t, "t5_release_wait");
            step(0, 2'b00, 2'b00, 2'b00, 2'b01, new_t, "t5_fall");
            step(0, 2'b00, 2'b00, 2'b00, 2'b00, new_t, "t5_idle");
        end

        // Test 6: reset mid-count on ch1 discards progress
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t6_reset");
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "t6_reset");
        for (int k = 0; k < 3; k++)
            step(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t6_count");
        for (int k = 0; k < 2; k++)
            step(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t6_mid_reset");
        for (int k = 0; k < 5; k++)
            step(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "t6_restart_wait");
        step(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, "t6_rise");
        step(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, "t6_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
